// File: rtl/tap_pkg.sv
// Shared TAP definitions: 1149.1 state encoding, instruction opcodes and the IR capture pattern.
package tap_pkg;

    typedef logic [3:0] tap_state_t;

    localparam tap_state_t ST_TEST_LOGIC_RESET = 4'hF;
    localparam tap_state_t ST_RUN_TEST_IDLE    = 4'hC;
    localparam tap_state_t ST_SELECT_DR        = 4'h7;
    localparam tap_state_t ST_CAPTURE_DR       = 4'h6;
    localparam tap_state_t ST_SHIFT_DR         = 4'h2;
    localparam tap_state_t ST_EXIT1_DR         = 4'h1;
    localparam tap_state_t ST_PAUSE_DR         = 4'h3;
    localparam tap_state_t ST_EXIT2_DR         = 4'h0;
    localparam tap_state_t ST_UPDATE_DR        = 4'h5;
    localparam tap_state_t ST_SELECT_IR        = 4'h4;
    localparam tap_state_t ST_CAPTURE_IR       = 4'hE;
    localparam tap_state_t ST_SHIFT_IR         = 4'hA;
    localparam tap_state_t ST_EXIT1_IR         = 4'h9;
    localparam tap_state_t ST_PAUSE_IR         = 4'hB;
    localparam tap_state_t ST_EXIT2_IR         = 4'h8;
    localparam tap_state_t ST_UPDATE_IR        = 4'hD;

    localparam logic [3:0] OP_EXTEST   = 4'b0000;
    localparam logic [3:0] OP_IDCODE   = 4'b0001;
    localparam logic [3:0] OP_SAMPLE   = 4'b0010;
    localparam logic [3:0] OP_INTEST   = 4'b0011;
    localparam logic [3:0] OP_USERCODE = 4'b0100;
    localparam logic [3:0] OP_RUNBIST  = 4'b0101;
    localparam logic [3:0] OP_GETTEST  = 4'b0110;
    localparam logic [3:0] OP_BYPASS   = 4'b1111;

    localparam logic [3:0] IR_CAPTURE  = 4'b0001;

endpackage

// File: rtl/tap_fsm.sv
// 16-state IEEE 1149.1 TAP controller state machine, advanced by TMS on the TCK rising edge.
module tap_fsm
    import tap_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST_N,
    input  logic       TMS,
    output logic [3:0] TAP_STATE
);

    tap_state_t state_q, state_d;

    // Standard TMS transition table
    always_comb begin
        state_d = ST_TEST_LOGIC_RESET;
        case (state_q)
            ST_TEST_LOGIC_RESET: state_d = TMS ? ST_TEST_LOGIC_RESET : ST_RUN_TEST_IDLE;
            ST_RUN_TEST_IDLE:    state_d = TMS ? ST_SELECT_DR        : ST_RUN_TEST_IDLE;
            ST_SELECT_DR:        state_d = TMS ? ST_SELECT_IR        : ST_CAPTURE_DR;
            ST_CAPTURE_DR:       state_d = TMS ? ST_EXIT1_DR         : ST_SHIFT_DR;
            ST_SHIFT_DR:         state_d = TMS ? ST_EXIT1_DR         : ST_SHIFT_DR;
            ST_EXIT1_DR:         state_d = TMS ? ST_UPDATE_DR        : ST_PAUSE_DR;
            ST_PAUSE_DR:         state_d = TMS ? ST_EXIT2_DR         : ST_PAUSE_DR;
            ST_EXIT2_DR:         state_d = TMS ? ST_UPDATE_DR        : ST_SHIFT_DR;
            ST_UPDATE_DR:        state_d = TMS ? ST_SELECT_DR        : ST_RUN_TEST_IDLE;
            ST_SELECT_IR:        state_d = TMS ? ST_TEST_LOGIC_RESET : ST_CAPTURE_IR;
            ST_CAPTURE_IR:       state_d = TMS ? ST_EXIT1_IR         : ST_SHIFT_IR;
            ST_SHIFT_IR:         state_d = TMS ? ST_EXIT1_IR         : ST_SHIFT_IR;
            ST_EXIT1_IR:         state_d = TMS ? ST_UPDATE_IR        : ST_PAUSE_IR;
            ST_PAUSE_IR:         state_d = TMS ? ST_EXIT2_IR         : ST_PAUSE_IR;
            ST_EXIT2_IR:         state_d = TMS ? ST_UPDATE_IR        : ST_SHIFT_IR;
            ST_UPDATE_IR:        state_d = TMS ? ST_SELECT_DR        : ST_RUN_TEST_IDLE;
            default:             state_d = ST_TEST_LOGIC_RESET;
        endcase
    end

    // State register
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            state_q <= ST_TEST_LOGIC_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    assign TAP_STATE = state_q;

endmodule

// File: rtl/tap_ctrl.sv
// TAP controller top: IR shift/latch, instruction decode and falling-edge TDO mux.
// Optional bypass register enabled by defining TAP_CTRL_BYPASS_EN.
module tap_ctrl
    import tap_pkg::*;
#(
    parameter int IR_WIDTH = 4
) (
    input  logic       TCK,
    input  logic       TRST_N,
    input  logic       TMS,
    input  logic       TDI,
    output logic       TDO,
    output logic       TDO_EN,
    output logic       CAPTUREDR,
    output logic       SHIFTDR,
    output logic       UPDATEDR,
    output logic       IDCODE_SELECT,
    output logic       SAMPLE_SELECT,
    output logic       EXTEST_SELECT,
    output logic       INTEST_SELECT,
    output logic       USERCODE_SELECT,
    output logic       RUNBIST_SELECT,
    output logic       GETTEST_SELECT,
    input  logic       ID_REG_TDO,
    input  logic       USERCODE_REG_TDO,
    input  logic       BSR_TDO,
    input  logic       STATUS_BIST_TDO,
    output logic [3:0] TAP_STATE
);

    tap_state_t          state_s;
    logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
    logic [IR_WIDTH-1:0] ir_latch_q, ir_latch_d;
    logic                tdo_q, tdo_d;
    logic                tdo_en_q, tdo_en_d;
    logic                dr_tdo_s, bypass_tdo_s, tlr_entry_s;

    tap_fsm u_fsm (
        .TCK       (TCK),
        .TRST_N    (TRST_N),
        .TMS       (TMS),
        .TAP_STATE (state_s)
    );

    assign TAP_STATE = state_s;
    assign CAPTUREDR = (state_s == ST_CAPTURE_DR);
    assign SHIFTDR   = (state_s == ST_SHIFT_DR);
    assign UPDATEDR  = (state_s == ST_UPDATE_DR);

    // TEST_LOGIC_RESET is only ever entered from SELECT_IR (or itself) with TMS high
    assign tlr_entry_s = (state_s == ST_TEST_LOGIC_RESET) ||
                         ((state_s == ST_SELECT_IR) && TMS);

    // IR shift register and instruction latch next state
    always_comb begin
        ir_shift_d = ir_shift_q;
        ir_latch_d = ir_latch_q;
        case (state_s)
            ST_CAPTURE_IR: ir_shift_d = IR_WIDTH'(IR_CAPTURE);
            ST_SHIFT_IR:   ir_shift_d = {TDI, ir_shift_q[IR_WIDTH-1:1]};
            default:       ir_shift_d = ir_shift_q;
        endcase
        if (tlr_entry_s) begin
            ir_latch_d = IR_WIDTH'(OP_IDCODE);
        end else if (state_s == ST_UPDATE_IR) begin
            ir_latch_d = ir_shift_q;
        end else begin
            ir_latch_d = ir_latch_q;
        end
    end

    // IR registers
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            ir_shift_q <= '0;
            ir_latch_q <= IR_WIDTH'(OP_IDCODE);
        end else begin
            ir_shift_q <= ir_shift_d;
            ir_latch_q <= ir_latch_d;
        end
    end

    assign IDCODE_SELECT   = (ir_latch_q == IR_WIDTH'(OP_IDCODE));
    assign SAMPLE_SELECT   = (ir_latch_q == IR_WIDTH'(OP_SAMPLE));
    assign EXTEST_SELECT   = (ir_latch_q == IR_WIDTH'(OP_EXTEST));
    assign INTEST_SELECT   = (ir_latch_q == IR_WIDTH'(OP_INTEST));
    assign USERCODE_SELECT = (ir_latch_q == IR_WIDTH'(OP_USERCODE));
    assign RUNBIST_SELECT  = (ir_latch_q == IR_WIDTH'(OP_RUNBIST));
    assign GETTEST_SELECT  = (ir_latch_q == IR_WIDTH'(OP_GETTEST));

`ifdef TAP_CTRL_BYPASS_EN
    logic bypass_q, bypass_d;

    // Bypass bit: captures 0, then samples TDI while shifting
    always_comb begin
        case (state_s)
            ST_CAPTURE_DR: bypass_d = 1'b0;
            ST_SHIFT_DR:   bypass_d = TDI;
            default:       bypass_d = bypass_q;
        endcase
    end

    // Bypass register
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            bypass_q <= 1'b0;
        end else begin
            bypass_q <= bypass_d;
        end
    end

    assign bypass_tdo_s = bypass_q;
`else
    assign bypass_tdo_s = 1'b0;
`endif

    // DR source selection by current instruction
    always_comb begin
        case (ir_latch_q)
            IR_WIDTH'(OP_IDCODE):   dr_tdo_s = ID_REG_TDO;
            IR_WIDTH'(OP_USERCODE): dr_tdo_s = USERCODE_REG_TDO;
            IR_WIDTH'(OP_RUNBIST):  dr_tdo_s = STATUS_BIST_TDO;
            IR_WIDTH'(OP_SAMPLE),
            IR_WIDTH'(OP_EXTEST),
            IR_WIDTH'(OP_INTEST),
            IR_WIDTH'(OP_GETTEST):  dr_tdo_s = BSR_TDO;
            default:                dr_tdo_s = bypass_tdo_s;
        endcase
    end

    // TDO / TDO_EN next value, held outside the shift states
    always_comb begin
        tdo_en_d = (state_s == ST_SHIFT_IR) || (state_s == ST_SHIFT_DR);
        if (state_s == ST_SHIFT_IR) begin
            tdo_d = ir_shift_q[0];
        end else if (state_s == ST_SHIFT_DR) begin
            tdo_d = dr_tdo_s;
        end else begin
            tdo_d = tdo_q;
        end
    end

    // Falling-edge output registers
    always_ff @(negedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    assign TDO    = tdo_q;
    assign TDO_EN = tdo_en_q;

endmodule

// File: tb/tb_tap_ctrl.sv
// Scoreboard bench for tap_ctrl: a table-driven TAP model predicts every cycle, a monitor compares.
module tb_tap_ctrl;
    import tap_pkg::*;

    logic       TCK = 1'b0, TRST_N = 1'b0, TMS = 1'b1, TDI = 1'b0;
    logic       ID_REG_TDO = 1'b0, USERCODE_REG_TDO = 1'b0, BSR_TDO = 1'b0, STATUS_BIST_TDO = 1'b0;
    logic       TDO, TDO_EN, CAPTUREDR, SHIFTDR, UPDATEDR;
    logic       IDCODE_SELECT, SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT;
    logic       USERCODE_SELECT, RUNBIST_SELECT, GETTEST_SELECT;
    logic [3:0] TAP_STATE;

    tap_ctrl #(.IR_WIDTH(4)) dut (
        .TCK(TCK), .TRST_N(TRST_N), .TMS(TMS), .TDI(TDI),
        .TDO(TDO), .TDO_EN(TDO_EN),
        .CAPTUREDR(CAPTUREDR), .SHIFTDR(SHIFTDR), .UPDATEDR(UPDATEDR),
        .IDCODE_SELECT(IDCODE_SELECT), .SAMPLE_SELECT(SAMPLE_SELECT),
        .EXTEST_SELECT(EXTEST_SELECT), .INTEST_SELECT(INTEST_SELECT),
        .USERCODE_SELECT(USERCODE_SELECT), .RUNBIST_SELECT(RUNBIST_SELECT),
        .GETTEST_SELECT(GETTEST_SELECT),
        .ID_REG_TDO(ID_REG_TDO), .USERCODE_REG_TDO(USERCODE_REG_TDO),
        .BSR_TDO(BSR_TDO), .STATUS_BIST_TDO(STATUS_BIST_TDO),
        .TAP_STATE(TAP_STATE)
    );

    always #5 TCK = ~TCK;

    typedef struct {
        logic [3:0] st;
        logic [2:0] strb;
        logic [6:0] sel;
        logic       tdo;
        logic       en;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] nx0[16];
    logic [3:0] nx1[16];

    // Reference model state
    logic [3:0] m_st, m_ir, m_irsh;
    logic       m_byp, m_tdo, m_en;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tr(logic [3:0] s, logic [3:0] n0, logic [3:0] n1);
        nx0[s] = n0;
        nx1[s] = n1;
    endtask

    // {IDCODE, SAMPLE, EXTEST, INTEST, USERCODE, RUNBIST, GETTEST}
    function automatic logic [6:0] sel_of(logic [3:0] op);
        case (op)
            OP_IDCODE:   return 7'b1000000;
            OP_SAMPLE:   return 7'b0100000;
            OP_EXTEST:   return 7'b0010000;
            OP_INTEST:   return 7'b0001000;
            OP_USERCODE: return 7'b0000100;
            OP_RUNBIST:  return 7'b0000010;
            OP_GETTEST:  return 7'b0000001;
            default:     return 7'b0000000;
        endcase
    endfunction

    function automatic logic dr_src(logic [3:0] op);
        case (op)
            OP_IDCODE:   return ID_REG_TDO;
            OP_USERCODE: return USERCODE_REG_TDO;
            OP_RUNBIST:  return STATUS_BIST_TDO;
            OP_SAMPLE, OP_EXTEST, OP_INTEST, OP_GETTEST: return BSR_TDO;
`ifdef TAP_CTRL_BYPASS_EN
            default:     return m_byp;
`else
            default:     return 1'b0;
`endif
        endcase
    endfunction

    function automatic logic [6:0] dut_sel();
        return {IDCODE_SELECT, SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT,
                USERCODE_SELECT, RUNBIST_SELECT, GETTEST_SELECT};
    endfunction

    task automatic model_reset();
        m_st = ST_TEST_LOGIC_RESET; m_ir = OP_IDCODE; m_irsh = 4'd0;
        m_byp = 1'b0; m_tdo = 1'b0; m_en = 1'b0;
    endtask

    // One TCK cycle: drive, let the model follow the edge, queue the prediction
    task automatic tick(logic tms, logic tdi);
        logic [3:0] old_st;
        exp_t e;
        TMS = tms; TDI = tdi;
        ID_REG_TDO = 1'($urandom); USERCODE_REG_TDO = 1'($urandom);
        BSR_TDO = 1'($urandom); STATUS_BIST_TDO = 1'($urandom);
        @(posedge TCK);
        old_st = m_st;
        m_st = tms ? nx1[old_st] : nx0[old_st];
        if (old_st == ST_UPDATE_IR) m_ir = m_irsh;
        if (old_st == ST_CAPTURE_IR) m_irsh = 4'b0001;
        else if (old_st == ST_SHIFT_IR) m_irsh = {tdi, m_irsh[3:1]};
        if (old_st == ST_CAPTURE_DR) m_byp = 1'b0;
        else if (old_st == ST_SHIFT_DR) m_byp = tdi;
        if (m_st == ST_TEST_LOGIC_RESET) m_ir = OP_IDCODE;
        if (m_st == ST_SHIFT_IR) m_tdo = m_irsh[0];
        else if (m_st == ST_SHIFT_DR) m_tdo = dr_src(m_ir);
        m_en = (m_st == ST_SHIFT_IR) || (m_st == ST_SHIFT_DR);
        e.st = m_st;
        e.strb = {m_st == ST_CAPTURE_DR, m_st == ST_SHIFT_DR, m_st == ST_UPDATE_DR};
        e.sel = sel_of(m_ir);
        e.tdo = m_tdo;
        e.en = m_en;
        sb.push_back(e);
        @(negedge TCK);
        #2;
    endtask

    task automatic load_ir(logic [3:0] op);
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(i == 3, op[i]);
        tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    endtask

    task automatic dr_scan(int n, logic [7:0] bits);
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick(i == n - 1, bits[i]);
        tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    endtask

    // Monitor: compares each queued prediction after the rising and falling edges
    initial begin
        exp_t e;
        forever begin
            @(posedge TCK);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("state", TAP_STATE, e.st);
                chk("strobes", {CAPTUREDR, SHIFTDR, UPDATEDR}, e.strb);
                chk("selects", dut_sel(), e.sel);
                @(negedge TCK);
                #1;
                chk("tdo", TDO, e.tdo);
                chk("tdo_en", TDO_EN, e.en);
            end
        end
    end

    initial begin
        logic [3:0] ops[8];
        tr(ST_TEST_LOGIC_RESET, ST_RUN_TEST_IDLE, ST_TEST_LOGIC_RESET);
        tr(ST_RUN_TEST_IDLE, ST_RUN_TEST_IDLE, ST_SELECT_DR);
        tr(ST_SELECT_DR, ST_CAPTURE_DR, ST_SELECT_IR);
        tr(ST_CAPTURE_DR, ST_SHIFT_DR, ST_EXIT1_DR);
        tr(ST_SHIFT_DR, ST_SHIFT_DR, ST_EXIT1_DR);
        tr(ST_EXIT1_DR, ST_PAUSE_DR, ST_UPDATE_DR);
        tr(ST_PAUSE_DR, ST_PAUSE_DR, ST_EXIT2_DR);
        tr(ST_EXIT2_DR, ST_SHIFT_DR, ST_UPDATE_DR);
        tr(ST_UPDATE_DR, ST_RUN_TEST_IDLE, ST_SELECT_DR);
        tr(ST_SELECT_IR, ST_CAPTURE_IR, ST_TEST_LOGIC_RESET);
        tr(ST_CAPTURE_IR, ST_SHIFT_IR, ST_EXIT1_IR);
        tr(ST_SHIFT_IR, ST_SHIFT_IR, ST_EXIT1_IR);
        tr(ST_EXIT1_IR, ST_PAUSE_IR, ST_UPDATE_IR);
        tr(ST_PAUSE_IR, ST_PAUSE_IR, ST_EXIT2_IR);
        tr(ST_EXIT2_IR, ST_SHIFT_IR, ST_UPDATE_IR);
        tr(ST_UPDATE_IR, ST_RUN_TEST_IDLE, ST_SELECT_DR);
        model_reset();

        #12;
        chk("rst_state", TAP_STATE, ST_TEST_LOGIC_RESET);
        chk("rst_idsel", dut_sel(), 7'b1000000);
        chk("rst_tdo", {TDO, TDO_EN}, 2'b00);
        @(negedge TCK);
        #2;
        TRST_N = 1'b1;
        tick(1'b0, 1'b0);

        // USERCODE load then a 3-bit DR scan
        load_ir(OP_USERCODE);
        dr_scan(3, 8'($urandom));
        // BYPASS with pattern 1,0,1,1
        load_ir(OP_BYPASS);
        dr_scan(4, 8'b0000_1101);
        // Unassigned opcode
        load_ir(4'b1010);
        dr_scan(4, 8'b0000_1101);

        ops = '{OP_EXTEST, OP_IDCODE, OP_SAMPLE, OP_INTEST, OP_RUNBIST, OP_GETTEST, 4'b0111, OP_USERCODE};
        foreach (ops[k]) begin
            load_ir(ops[k]);
            dr_scan(5, 8'($urandom));
        end

        // Five TMS=1 edges from SHIFT_IR
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
        chk("not_yet_tlr", TAP_STATE == ST_TEST_LOGIC_RESET, 1'b0);
        tick(1'b1, 1'b0);
        chk("tms5_tlr", TAP_STATE, ST_TEST_LOGIC_RESET);
        tick(1'b0, 1'b0);

        // Random TMS/TDI walk
        for (int i = 0; i < 400; i++) tick($urandom_range(0, 2) == 0, 1'($urandom));
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);

        // Asynchronous reset in the middle of SHIFT_DR
        load_ir(OP_USERCODE);
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b1);
        chk("pre_rst_shiftdr", {SHIFTDR, TDO_EN}, 2'b11);
        #1;
        TRST_N = 1'b0;
        #1;
        model_reset();
        chk("midrst_state", TAP_STATE, ST_TEST_LOGIC_RESET);
        chk("midrst_idsel", dut_sel(), 7'b1000000);
        chk("midrst_strobes", {CAPTUREDR, SHIFTDR, UPDATEDR}, 3'b000);
        chk("midrst_tdo", {TDO, TDO_EN}, 2'b00);
        @(negedge TCK);
        #2;
        TRST_N = 1'b1;
        tick(1'b0, 1'b0);
        load_ir(OP_RUNBIST);
        dr_scan(4, 8'($urandom));

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge TCK);
        #20;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
